// File: rtl/cond_eval.sv
// cond_eval
// ---------
// Condition-evaluation and nullification stage feeding the PSW register.
// Every cycle it evaluates the PA-RISC compare/branch condition on the
// EX-stage ALU result and flags, decides whether a branch is taken, and
// keeps a one-deep "nullify next instruction" state that survives bubbles
// and stalls. The registered outputs drive the PSW nullify input, the PSW
// carry input and the PSW write enable.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   EX_VALID     EX stage holds a real instruction (0 = bubble)
//   STALL        pipeline hold, no state change
//   COND_CLASS   00 none, 01 compare-and-nullify, 10 cond branch, 11 uncond branch
//   C            condition field
//   F            negate condition
//   N_BIT        instruction n bit
//   BR_BACKWARD  branch displacement is negative
//   RESULT       ALU result (a-b for compares)
//   C_B          ALU carry/borrow (1 = no borrow)
//   OVF          ALU signed overflow
//   COND_TRUE    evaluated condition after F (combinational)
//   BR_TAKEN     branch taken, to fetch (combinational)
//   NULLIFY_EX   current EX instruction is squashed (combinational)
//   N_in         registered nullify-pending, to PSW
//   C_B_Q        registered carry, to PSW
//   PSW_EN       registered one-cycle PSW write pulse
module cond_eval #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             EX_VALID,
   input  logic             STALL,
   input  logic [1:0]       COND_CLASS,
   input  logic [2:0]       C,
   input  logic             F,
   input  logic             N_BIT,
   input  logic             BR_BACKWARD,
   input  logic [WIDTH-1:0] RESULT,
   input  logic             C_B,
   input  logic             OVF,
   output logic             COND_TRUE,
   output logic             BR_TAKEN,
   output logic             NULLIFY_EX,
   output logic             N_in,
   output logic             C_B_Q,
   output logic             PSW_EN
);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t state_q;
   logic   carry_q;
   logic   pswEn_q;

   logic   pending;
   logic   live;
   logic   isZero;
   logic   signedLess;
   logic   rawCond;
   logic   taken;
   logic   newNull;

   assign pending    = (state_q == PEND);
   assign live       = EX_VALID & ~pending;
   assign isZero     = (RESULT == '0);
   assign signedLess = RESULT[WIDTH-1] ^ OVF;

   // Raw condition decode, before the F negate bit is applied.
   always_comb begin
      rawCond = 1'b0;
      case (C)
         3'd0:    rawCond = 1'b0;
         3'd1:    rawCond = isZero;
         3'd2:    rawCond = signedLess;
         3'd3:    rawCond = signedLess | isZero;
         3'd4:    rawCond = ~C_B;
         3'd5:    rawCond = ~C_B | isZero;
         3'd6:    rawCond = OVF;
         default: rawCond = RESULT[0];
      endcase
   end

   assign COND_TRUE = rawCond ^ F;

   // Per-class branch decision and nullify request. A conditional branch
   // nullifies its delay slot when it is a forward taken branch or a
   // backward not-taken branch, and only when the n bit is set.
   always_comb begin
      taken   = 1'b0;
      newNull = 1'b0;
      case (COND_CLASS)
         2'b01: begin
            taken   = 1'b0;
            newNull = COND_TRUE;
         end
         2'b10: begin
            taken   = COND_TRUE;
            newNull = N_BIT & (COND_TRUE ^ BR_BACKWARD);
         end
         2'b11: begin
            taken   = 1'b1;
            newNull = N_BIT;
         end
         default: begin
            taken   = 1'b0;
            newNull = 1'b0;
         end
      endcase
   end

   assign BR_TAKEN   = live & ~STALL & taken;
   assign NULLIFY_EX = EX_VALID & pending;

   // Nullify FSM with registered PSW outputs. Only an advancing valid
   // instruction changes state; a squashed instruction consumes the pending
   // state, clears the carry, and its own decision is thrown away so that
   // nullification never chains.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         carry_q <= 1'b0;
         pswEn_q <= 1'b0;
      end else if (STALL || !EX_VALID) begin
         pswEn_q <= 1'b0;
      end else begin
         pswEn_q <= 1'b1;
         case (state_q)
            IDLE: begin
               carry_q <= C_B;
               state_q <= newNull ? PEND : IDLE;
            end
            default: begin
               carry_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign N_in   = pending;
   assign C_B_Q  = carry_q;
   assign PSW_EN = pswEn_q;

endmodule
